// File: rtl/chimera_pkg.sv
// Shared types and defaults for the Chimera cluster power sequencer.
package chimera_pkg;

   localparam int unsigned ExtClusters      = 2;
   localparam int unsigned DefRstHoldCycles = 4;
   localparam int unsigned DefSettleCycles  = 2;
   localparam int unsigned DefTimeoutCycles = 1024;

   typedef enum logic [2:0] {
      CLU_OFF     = 3'd0,
      CLU_CLK_ON  = 3'd1,
      CLU_RST_REL = 3'd2,
      CLU_DEISO   = 3'd3,
      CLU_ON      = 3'd4,
      CLU_ISO     = 3'd5,
      CLU_RST_ON  = 3'd6
   } clu_pwr_state_e;

   // Per-cluster output bundle, registered once per cycle from the state.
   typedef struct packed {
      logic isolate;
      logic clk_en;
      logic rst_n;
      logic busy;
      logic on;
   } clu_pwr_out_t;

   function automatic clu_pwr_out_t decode_state(clu_pwr_state_e s);
      clu_pwr_out_t o;
      o = '{isolate: 1'b1, clk_en: 1'b0, rst_n: 1'b0, busy: 1'b0, on: 1'b0};
      case (s)
         CLU_OFF:     o = '{isolate: 1'b1, clk_en: 1'b0, rst_n: 1'b0, busy: 1'b0, on: 1'b0};
         CLU_CLK_ON:  o = '{isolate: 1'b1, clk_en: 1'b1, rst_n: 1'b0, busy: 1'b1, on: 1'b0};
         CLU_RST_REL: o = '{isolate: 1'b1, clk_en: 1'b1, rst_n: 1'b1, busy: 1'b1, on: 1'b0};
         CLU_DEISO:   o = '{isolate: 1'b0, clk_en: 1'b1, rst_n: 1'b1, busy: 1'b1, on: 1'b0};
         CLU_ON:      o = '{isolate: 1'b0, clk_en: 1'b1, rst_n: 1'b1, busy: 1'b0, on: 1'b1};
         CLU_ISO:     o = '{isolate: 1'b1, clk_en: 1'b1, rst_n: 1'b1, busy: 1'b1, on: 1'b0};
         CLU_RST_ON:  o = '{isolate: 1'b1, clk_en: 1'b1, rst_n: 1'b0, busy: 1'b1, on: 1'b0};
         default:     o = '{isolate: 1'b1, clk_en: 1'b0, rst_n: 1'b0, busy: 1'b0, on: 1'b0};
      endcase
      return o;
   endfunction

   function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/chimera_clu_pwr_fsm.sv
// Single-cluster isolation / clock / reset sequencer with timeout flag.
module chimera_clu_pwr_fsm
   import chimera_pkg::*;
#(
   parameter bit          BootOn        = 1'b0,
   parameter bit          IsoPresent    = 1'b1,
   parameter int unsigned RstHoldCycles = DefRstHoldCycles,
   parameter int unsigned SettleCycles  = DefSettleCycles,
   parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic err_clr,
   input  logic isolated,
   output logic isolate,
   output logic clk_en,
   output logic clu_rst_n,
   output logic busy,
   output logic on,
   output logic err
);

   localparam int unsigned MaxCycles = max3(RstHoldCycles, SettleCycles, TimeoutCycles);
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);
   typedef logic [CntW-1:0] cnt_t;

   localparam cnt_t RstHoldLd = cnt_t'(RstHoldCycles);
   localparam cnt_t SettleLd  = cnt_t'(SettleCycles);
   localparam cnt_t TimeoutLd = cnt_t'(TimeoutCycles);
   localparam cnt_t CntOne    = cnt_t'(1);
   localparam clu_pwr_state_e BootState = BootOn ? CLU_ON : CLU_OFF;

   clu_pwr_state_e state, state_nxt;
   cnt_t           cnt, cnt_nxt;
   clu_pwr_out_t   outs;
   logic           expire;
   logic           iso_done, deiso_done;

   // Without isolation cells the handshake completes immediately.
   assign iso_done   = IsoPresent ? isolated  : 1'b1;
   assign deiso_done = IsoPresent ? !isolated : 1'b1;

   // Next state and counter; a timed state exits on the cycle its count is 1.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = (cnt > CntOne) ? cnt - CntOne : cnt;
      expire    = 1'b0;
      case (state)
         CLU_OFF: if (en) begin
            state_nxt = CLU_CLK_ON;
            cnt_nxt   = RstHoldLd;
         end
         CLU_CLK_ON: if (cnt == CntOne) begin
            state_nxt = CLU_RST_REL;
            cnt_nxt   = SettleLd;
         end
         CLU_RST_REL: if (cnt == CntOne) begin
            state_nxt = CLU_DEISO;
            cnt_nxt   = '0;
         end
         CLU_DEISO: if (deiso_done) state_nxt = CLU_ON;
         CLU_ON: if (!en) begin
            state_nxt = CLU_ISO;
            cnt_nxt   = TimeoutLd;
         end
         CLU_ISO: begin
            // Abort wins over completion; on timeout we stay isolated with the clock running.
            if (en) begin
               state_nxt = CLU_DEISO;
               cnt_nxt   = '0;
            end else if (iso_done) begin
               state_nxt = CLU_RST_ON;
               cnt_nxt   = RstHoldLd;
            end else if (cnt == CntOne) begin
               expire  = 1'b1;
               cnt_nxt = '0;
            end
         end
         CLU_RST_ON: if (cnt == CntOne) begin
            state_nxt = CLU_OFF;
            cnt_nxt   = '0;
         end
         default: begin
            state_nxt = CLU_OFF;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= BootState;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Sticky timeout flag; a set in the same cycle as a clear wins.
   always_ff @(posedge clk) begin
      if (!rst_n)       err <= 1'b0;
      else if (expire)  err <= 1'b1;
      else if (err_clr) err <= 1'b0;
   end

   // Output register, one cycle behind the state.
   always_ff @(posedge clk) begin
      if (!rst_n) outs <= decode_state(BootState);
      else        outs <= decode_state(state);
   end

   assign isolate   = outs.isolate;
   assign clk_en    = outs.clk_en;
   assign clu_rst_n = outs.rst_n;
   assign busy      = outs.busy;
   assign on        = outs.on;

endmodule

// File: rtl/chimera_clu_pwr_ctrl.sv
// Per-cluster power sequencer array between the register file and cluster domains.
module chimera_clu_pwr_ctrl
   import chimera_pkg::*;
#(
   parameter int unsigned            NumClusters   = ExtClusters,
   parameter logic [NumClusters-1:0] BootOn        = '0,
   parameter bit                     IsoPresent    = 1'b1,
   parameter int unsigned            RstHoldCycles = DefRstHoldCycles,
   parameter int unsigned            SettleCycles  = DefSettleCycles,
   parameter int unsigned            TimeoutCycles = DefTimeoutCycles
) (
   input  logic                   soc_clk_i,
   input  logic                   rst_ni,
   input  logic [NumClusters-1:0] en_i,
   input  logic [NumClusters-1:0] err_clr_i,
   input  logic [NumClusters-1:0] isolated_i,
   output logic [NumClusters-1:0] isolate_o,
   output logic [NumClusters-1:0] clu_clk_en_o,
   output logic [NumClusters-1:0] clu_rst_no,
   output logic [NumClusters-1:0] busy_o,
   output logic [NumClusters-1:0] on_o,
   output logic [NumClusters-1:0] err_o
);

   for (genvar i = 0; i < NumClusters; i++) begin : g_clu
      chimera_clu_pwr_fsm #(
         .BootOn        (BootOn[i]),
         .IsoPresent    (IsoPresent),
         .RstHoldCycles (RstHoldCycles),
         .SettleCycles  (SettleCycles),
         .TimeoutCycles (TimeoutCycles)
      ) u_fsm (
         .clk       (soc_clk_i),
         .rst_n     (rst_ni),
         .en        (en_i[i]),
         .err_clr   (err_clr_i[i]),
         .isolated  (isolated_i[i]),
         .isolate   (isolate_o[i]),
         .clk_en    (clu_clk_en_o[i]),
         .clu_rst_n (clu_rst_no[i]),
         .busy      (busy_o[i]),
         .on        (on_o[i]),
         .err       (err_o[i])
      );
   end

endmodule
